// File: rtl/trigger_pkg.sv
// Shared definitions for the trigger register bank: mode encodings and helpers.
package trigger_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_HOLD   = 3'b000,
      MODE_LOAD   = 3'b001,
      MODE_JK     = 3'b010,
      MODE_TOGGLE = 3'b011,
      MODE_SHL    = 3'b100,
      MODE_SHR    = 3'b101,
      MODE_ROL    = 3'b110,
      MODE_RSVD   = 3'b111
   } mode_e;

   // Modes that move a bit out through the serial output.
   function automatic logic is_shift(input logic [MODE_W-1:0] m);
      return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL);
   endfunction

endpackage

// File: rtl/trigger_cell.sv
// One bit of the trigger register: next-state selection plus its reset flop.
// With TRIG_CHANGE_FLAG_EN defined the next-state value is also exported.
module trigger_cell
   import trigger_pkg::*;
#(
   parameter logic RST_BIT = 1'b0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic [MODE_W-1:0] i_mode,
   input  logic              i_d,
   input  logic              i_j,
   input  logic              i_k,
   input  logic              i_shl_in,
   input  logic              i_shr_in,
   input  logic              i_rol_in,
`ifdef TRIG_CHANGE_FLAG_EN
   output logic              o_nxt,
`endif
   output logic              o_q
);

   logic r_q;
   logic w_nxt;

   always_comb begin
      w_nxt = r_q;
      if (i_en) begin
         case (i_mode)
            MODE_LOAD:   w_nxt = i_d;
            MODE_JK:     w_nxt = (i_j & ~r_q) | (~i_k & r_q);
            MODE_TOGGLE: w_nxt = r_q ^ i_d;
            MODE_SHL:    w_nxt = i_shl_in;
            MODE_SHR:    w_nxt = i_shr_in;
            MODE_ROL:    w_nxt = i_rol_in;
            default:     w_nxt = r_q;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_q <= RST_BIT;
      else          r_q <= w_nxt;
   end

   assign o_q = r_q;
`ifdef TRIG_CHANGE_FLAG_EN
   assign o_nxt = w_nxt;
`endif

endmodule

// File: rtl/trigger_reg_bank.sv
// WIDTH-bit clocked register of D/JK/T/shift trigger cells with serial I/O.
// Optional feature macro: TRIG_CHANGE_FLAG_EN adds the registered `changed` output.
module trigger_reg_bank
   import trigger_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic              c,
   input  logic              r_n,
   input  logic              en,
   input  logic [MODE_W-1:0] mode,
   input  logic [WIDTH-1:0]  d,
   input  logic [WIDTH-1:0]  j,
   input  logic [WIDTH-1:0]  k,
   input  logic              si,
   output logic [WIDTH-1:0]  q,
   output logic              so,
   output logic              bad_mode
`ifdef TRIG_CHANGE_FLAG_EN
   ,
   output logic              changed
`endif
);

   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_shl_in;
   logic [WIDTH-1:0] w_shr_in;
   logic [WIDTH-1:0] w_rol_in;
`ifdef TRIG_CHANGE_FLAG_EN
   logic [WIDTH-1:0] w_nxt;
`endif

   // Neighbour wiring; the end cells take si (shifts) or the far end (rotate),
   // which for WIDTH=1 makes ROL a hold and both shifts a load of si.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      if (gi == 0) begin : g_lo
         assign w_shl_in[gi] = si;
         assign w_rol_in[gi] = w_q[WIDTH-1];
      end else begin : g_lo
         assign w_shl_in[gi] = w_q[gi-1];
         assign w_rol_in[gi] = w_q[gi-1];
      end
      if (gi == WIDTH-1) begin : g_hi
         assign w_shr_in[gi] = si;
      end else begin : g_hi
         assign w_shr_in[gi] = w_q[gi+1];
      end

      trigger_cell #(
         .RST_BIT (RST_VAL[gi])
      ) u_cell (
         .i_clk    (c),
         .i_rst_n  (r_n),
         .i_en     (en),
         .i_mode   (mode),
         .i_d      (d[gi]),
         .i_j      (j[gi]),
         .i_k      (k[gi]),
         .i_shl_in (w_shl_in[gi]),
         .i_shr_in (w_shr_in[gi]),
         .i_rol_in (w_rol_in[gi]),
`ifdef TRIG_CHANGE_FLAG_EN
         .o_nxt    (w_nxt[gi]),
`endif
         .o_q      (w_q[gi])
      );
   end

   logic r_so;
   logic r_bad_mode;
   logic w_so_src;

   assign w_so_src = (mode == MODE_SHR) ? w_q[0] : w_q[WIDTH-1];

   always_ff @(posedge c or negedge r_n) begin
      if (!r_n) begin
         r_so       <= 1'b0;
         r_bad_mode <= 1'b0;
      end else begin
         if (en && is_shift(mode)) r_so <= w_so_src;
         r_bad_mode <= en && (mode == MODE_RSVD);
      end
   end

`ifdef TRIG_CHANGE_FLAG_EN
   logic r_changed;

   always_ff @(posedge c or negedge r_n) begin
      if (!r_n) r_changed <= 1'b0;
      else      r_changed <= (w_nxt != w_q);
   end

   assign changed = r_changed;
`endif

   assign q        = w_q;
   assign so       = r_so;
   assign bad_mode = r_bad_mode;

endmodule

// File: tb/tb_trigger_reg_bank.sv
// Self-checking bench for trigger_reg_bank (WIDTH=8, RST_VAL=0).
module tb_trigger_reg_bank;

   localparam int W  = 8;
`ifdef TRIG_CHANGE_FLAG_EN
   localparam int EW = W + 3;
`else
   localparam int EW = W + 2;
`endif

   logic         c;
   logic         r_n;
   logic         en;
   logic [2:0]   mode;
   logic [W-1:0] d;
   logic [W-1:0] j;
   logic [W-1:0] k;
   logic         si;
   logic [W-1:0] q;
   logic         so;
   logic         bad_mode;
`ifdef TRIG_CHANGE_FLAG_EN
   logic         changed;
`endif

   trigger_reg_bank #(
      .WIDTH   (W),
      .RST_VAL (8'h00)
   ) dut (
      .c        (c),
      .r_n      (r_n),
      .en       (en),
      .mode     (mode),
      .d        (d),
      .j        (j),
      .k        (k),
      .si       (si),
      .q        (q),
      .so       (so),
      .bad_mode (bad_mode)
`ifdef TRIG_CHANGE_FLAG_EN
      ,
      .changed  (changed)
`endif
   );

   // clock / reset
   initial c = 1'b0;
   always #5 c = ~c;

   int n_tests = 0;
   int n_fail  = 0;

   logic [EW-1:0] exp_q[$];
   logic [W-1:0]  m_q;
   logic          m_so;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour of one enabled/disabled clock edge.
   task automatic model_step(input logic i_en, input logic [2:0] i_mode,
                             input logic [W-1:0] i_d, input logic [W-1:0] i_j,
                             input logic [W-1:0] i_k, input logic i_si);
      logic [W-1:0] nq;
      logic         nso;
      logic         nbad;
      logic         nchg;
      nq   = m_q;
      nso  = m_so;
      nbad = 1'b0;
      if (i_en) begin
         case (i_mode)
            3'd1: nq = i_d;
            3'd2: for (int b = 0; b < W; b++) begin
                     case ({i_j[b], i_k[b]})
                        2'b10:   nq[b] = 1'b1;
                        2'b01:   nq[b] = 1'b0;
                        2'b11:   nq[b] = ~m_q[b];
                        default: nq[b] = m_q[b];
                     endcase
                  end
            3'd3: nq = m_q ^ i_d;
            3'd4: begin nq = {m_q[W-2:0], i_si};    nso = m_q[W-1]; end
            3'd5: begin nq = {i_si, m_q[W-1:1]};    nso = m_q[0];   end
            3'd6: begin nq = {m_q[W-2:0], m_q[W-1]}; nso = m_q[W-1]; end
            3'd7: nbad = 1'b1;
            default: ;
         endcase
      end
      nchg = (nq != m_q);
`ifdef TRIG_CHANGE_FLAG_EN
      exp_q.push_back({nchg, nbad, nso, nq});
`else
      exp_q.push_back({nbad, nso, nq});
      if (nchg) ;
`endif
      m_q  = nq;
      m_so = nso;
   endtask

   // driver: apply inputs at the falling edge, compare after the rising edge
   task automatic step(input logic i_en, input logic [2:0] i_mode,
                       input logic [W-1:0] i_d, input logic [W-1:0] i_j,
                       input logic [W-1:0] i_k, input logic i_si);
      logic [EW-1:0] e;
      @(negedge c);
      en = i_en; mode = i_mode; d = i_d; j = i_j; k = i_k; si = i_si;
      model_step(i_en, i_mode, i_d, i_j, i_k, i_si);
      @(posedge c);
      #1;
      if (exp_q.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check("q", {24'd0, q}, {24'd0, e[W-1:0]});
         check("so", {31'd0, so}, {31'd0, e[W]});
         check("bad_mode", {31'd0, bad_mode}, {31'd0, e[W+1]});
`ifdef TRIG_CHANGE_FLAG_EN
         check("changed", {31'd0, changed}, {31'd0, e[W+2]});
`endif
      end
   endtask

   initial begin
      r_n = 1'b0; en = 1'b0; mode = 3'd0; d = '0; j = '0; k = '0; si = 1'b0;
      m_q = '0; m_so = 1'b0;
      #3;
      check("rst_q", {24'd0, q}, 32'h00);
      check("rst_so", {31'd0, so}, 32'd0);
      check("rst_bad", {31'd0, bad_mode}, 32'd0);
      @(negedge c);
      r_n = 1'b1;

      // 1: async reset mid-cycle after so has been set
      step(1, 3'd1, 8'h81, 0, 0, 0);
      step(1, 3'd4, 8'h00, 0, 0, 0);
      check("t1_so_pre", {31'd0, so}, 32'd1);
      step(1, 3'd1, 8'hA5, 0, 0, 0);
      @(negedge c);
      en = 1'b0;
      #2;
      r_n = 1'b0;
      #1;
      check("t1_async_q", {24'd0, q}, 32'h00);
      check("t1_async_so", {31'd0, so}, 32'd0);
      m_q = '0; m_so = 1'b0;
      @(negedge c);
      r_n = 1'b1;
      step(1, 3'd1, 8'h3C, 0, 0, 0);
      check("t1_load", {24'd0, q}, 32'h3C);

      // 2: JK
      step(1, 3'd2, 0, 8'hF0, 8'h0F, 0);
      check("t2_jk1", {24'd0, q}, 32'hF0);
      step(1, 3'd2, 0, 8'hFF, 8'hFF, 0);
      check("t2_jk2", {24'd0, q}, 32'h0F);

      // 3: toggle, then disabled load
      step(1, 3'd3, 8'hFF, 0, 0, 0);
      check("t3_tog", {24'd0, q}, 32'hF0);
      step(0, 3'd1, 8'h00, 0, 0, 0);
      check("t3_hold", {24'd0, q}, 32'hF0);

      // 4: shifts and rotate
      step(1, 3'd1, 8'h81, 0, 0, 0);
      step(1, 3'd4, 0, 0, 0, 0);
      check("t4_shl", {23'd0, so, q}, {23'd0, 1'b1, 8'h02});
      step(1, 3'd5, 0, 0, 0, 1);
      check("t4_shr", {23'd0, so, q}, {23'd0, 1'b0, 8'h81});
      step(1, 3'd6, 0, 0, 0, 0);
      check("t4_rol", {23'd0, so, q}, {23'd0, 1'b1, 8'h03});

      // 5: reserved mode
      step(1, 3'd1, 8'h55, 0, 0, 0);
      step(1, 3'd7, 8'hFF, 0, 0, 1);
      check("t5_bad1", {23'd0, bad_mode, q}, {23'd0, 1'b1, 8'h55});
      step(1, 3'd7, 8'hFF, 0, 0, 1);
      check("t5_bad2", {23'd0, bad_mode, q}, {23'd0, 1'b1, 8'h55});
      step(1, 3'd0, 8'hFF, 0, 0, 1);
      check("t5_bad_clr", {31'd0, bad_mode}, 32'd0);
      step(0, 3'd7, 8'hFF, 0, 0, 1);
      check("t5_bad_dis", {31'd0, bad_mode}, 32'd0);

`ifdef TRIG_CHANGE_FLAG_EN
      // 6: change flag
      step(1, 3'd1, 8'h55, 0, 0, 0);
      check("t6_same", {31'd0, changed}, 32'd0);
      step(1, 3'd1, 8'hAA, 0, 0, 0);
      check("t6_diff", {31'd0, changed}, 32'd1);
`endif

      // random traffic against the model
      for (int n = 0; n < 80; n++) begin
         step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end

      check("sb_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
